// File: rtl/pcie_phy_tx_os_scheduler_if.sv
// rtl/pcie_phy_tx_os_scheduler_if.sv - link-layer symbol stream into the TX ordered-set scheduler
interface pcie_phy_tx_os_scheduler_if;
  logic [7:0] tl_data;
  logic       tl_k;
  logic       tl_valid;
  logic       tl_last;
  logic       tl_ready;

  modport master (output tl_data, tl_k, tl_valid, tl_last, input tl_ready);
  modport slave  (input tl_data, tl_k, tl_valid, tl_last, output tl_ready);
endinterface

// File: rtl/pcie_phy_tx_os_scheduler.sv
// rtl/pcie_phy_tx_os_scheduler.sv - muxes packet symbols, logical idle and SKP ordered sets into the 8b10b encoder
module pcie_phy_tx_os_scheduler #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3,
  parameter int CNT_WIDTH    = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  pcie_phy_tx_os_scheduler_if.slave       tl,
  output logic [7:0]                      datain_tx_unencoded,
  output logic                            control_tx,
  output logic                            skp_sent,
  output logic                            skp_overrun,
  output logic                            pkt_underrun,
  output logic [1:0]                      sched_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_COM  = 2'd2,
    S_SKP  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(SKP_INTERVAL - 1);
  localparam logic [2:0]           SKP_LAST   = 3'(SKP_COUNT - 1);
  localparam logic [7:0]           SYM_COM    = 8'hBC;
  localparam logic [7:0]           SYM_SKP    = 8'h1C;

  state_t               state;
  logic [CNT_WIDTH-1:0] timer;
  logic                 pending;
  logic [2:0]           skp_cnt;
  logic                 wrap;
  logic                 last_skp;
  logic                 xfer;

  assign wrap        = (timer == TIMER_LAST);
  assign last_skp    = (state == S_SKP) && (skp_cnt == SKP_LAST);
  assign tl.tl_ready = !rst && ((state == S_PKT) || ((state == S_IDLE) && !pending));
  assign xfer        = tl.tl_valid && tl.tl_ready;
  assign sched_state = state;

  // A wrap coinciding with the last SKP keeps the request alive for the next set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      pending     <= 1'b0;
      skp_overrun <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + CNT_WIDTH'(1);
      if (wrap) begin
        pending <= 1'b1;
      end else if (last_skp) begin
        pending <= 1'b0;
      end
      if (wrap && pending) begin
        skp_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      skp_cnt             <= 3'd0;
      datain_tx_unencoded <= 8'h00;
      control_tx          <= 1'b0;
      skp_sent            <= 1'b0;
      pkt_underrun        <= 1'b0;
    end else begin
      skp_sent     <= 1'b0;
      pkt_underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pending) begin
            datain_tx_unencoded <= 8'h00;
            control_tx          <= 1'b0;
            state               <= S_COM;
          end else if (xfer) begin
            datain_tx_unencoded <= tl.tl_data;
            control_tx          <= tl.tl_k;
            if (!tl.tl_last) begin
              state <= S_PKT;
            end
          end else begin
            datain_tx_unencoded <= 8'h00;
            control_tx          <= 1'b0;
          end
        end
        S_PKT: begin
          if (xfer) begin
            datain_tx_unencoded <= tl.tl_data;
            control_tx          <= tl.tl_k;
            if (tl.tl_last) begin
              state <= (pending || wrap) ? S_COM : S_IDLE;
            end
          end else begin
            // Source starved mid-packet: pad with logical idle and flag it.
            datain_tx_unencoded <= 8'h00;
            control_tx          <= 1'b0;
            pkt_underrun        <= 1'b1;
          end
        end
        S_COM: begin
          datain_tx_unencoded <= SYM_COM;
          control_tx          <= 1'b1;
          skp_cnt             <= 3'd0;
          state               <= S_SKP;
        end
        S_SKP: begin
          datain_tx_unencoded <= SYM_SKP;
          control_tx          <= 1'b1;
          skp_cnt             <= skp_cnt + 3'd1;
          if (last_skp) begin
            skp_sent <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_phy_tx_os_scheduler.sv
// tb/tb_pcie_phy_tx_os_scheduler.sv - directed bench with packet scoreboard for the TX ordered-set scheduler
module tb_pcie_phy_tx_os_scheduler;
  localparam int SKP_INTERVAL = 16;
  localparam int SKP_COUNT    = 3;
  localparam int CNT_WIDTH    = 4;

  typedef struct packed {
    logic       last;
    logic       k;
    logic [7:0] data;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datain_tx_unencoded;
  logic       control_tx;
  logic       skp_sent;
  logic       skp_overrun;
  logic       pkt_underrun;
  logic [1:0] sched_state;

  int   compared   = 0;
  int   mismatched = 0;
  sym_t sb[$];
  logic mon_in_pkt = 1'b0;
  int   skp_left   = 0;
  int   sets       = 0;
  int   underruns  = 0;
  int   p, s0, u0;
  logic [8:0] exp_sym;
  logic [1:0] exp_st;

  pcie_phy_tx_os_scheduler_if tl ();

  pcie_phy_tx_os_scheduler #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .SKP_COUNT    (SKP_COUNT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tl                  (tl.slave),
    .datain_tx_unencoded (datain_tx_unencoded),
    .control_tx          (control_tx),
    .skp_sent            (skp_sent),
    .skp_overrun         (skp_overrun),
    .pkt_underrun        (pkt_underrun),
    .sched_state         (sched_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    tl.tl_valid = 1'b0;
    tl.tl_last  = 1'b0;
    tl.tl_k     = 1'b0;
    tl.tl_data  = 8'h00;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // First symbol is an STP-like K code, the rest are data bytes base+i.
  task automatic send_pkt(input int n, input logic [7:0] base, input int gap_at, input int gap_len);
    int   guard;
    sym_t s;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          tl.tl_valid = 1'b0;
        end
      end
      @(negedge clk);
      s.last      = (i == n - 1);
      s.k         = (i == 0);
      s.data      = (i == 0) ? 8'hFB : base + 8'(i);
      tl.tl_valid = 1'b1;
      tl.tl_data  = s.data;
      tl.tl_k     = s.k;
      tl.tl_last  = s.last;
      guard = 0;
      while (!tl.tl_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 64) check("tl_ready_wait", 32'd0, 32'd1);
      sb.push_back(s);
    end
    @(negedge clk);
    tl.tl_valid = 1'b0;
    tl.tl_last  = 1'b0;
  endtask

  // Output monitor: classifies each encoder symbol and checks it against the scoreboard.
  always @(negedge clk) begin
    sym_t e;
    if (rst) begin
      mon_in_pkt = 1'b0;
      skp_left   = 0;
    end else if (control_tx && datain_tx_unencoded == 8'hBC) begin
      check("com_outside_pkt", 32'(mon_in_pkt), 32'd0);
      check("com_outside_set", skp_left, 0);
      skp_left = SKP_COUNT;
    end else if (control_tx && datain_tx_unencoded == 8'h1C) begin
      check("skp_inside_set", 32'(skp_left != 0), 32'd1);
      if (skp_left > 0) skp_left--;
      check("skp_sent_pulse", 32'(skp_sent), 32'(skp_left == 0));
      if (skp_left == 0 && skp_sent) sets++;
    end else if (!control_tx && datain_tx_unencoded == 8'h00) begin
      check("idle_outside_set", skp_left, 0);
      check("underrun_flag", 32'(pkt_underrun), 32'(mon_in_pkt));
      if (mon_in_pkt) check("underrun_state", 32'(sched_state), 32'd1);
      if (pkt_underrun) underruns++;
    end else if (sb.size() == 0) begin
      check("unexpected_sym", {23'd0, control_tx, datain_tx_unencoded}, 32'h1FF);
    end else begin
      e = sb.pop_front();
      check("pkt_sym", {23'd0, control_tx, datain_tx_unencoded}, {23'd0, e.k, e.data});
      mon_in_pkt = !e.last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    tl.tl_valid = 1'b0;
    tl.tl_last  = 1'b0;
    tl.tl_k     = 1'b0;
    tl.tl_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_data",     datain_tx_unencoded, 8'h00);
    check("rst_ctl",      control_tx, 1'b0);
    check("rst_ready",    tl.tl_ready, 1'b0);
    check("rst_state",    sched_state, 2'd0);
    check("rst_overrun",  skp_overrun, 1'b0);
    check("rst_sent",     skp_sent, 1'b0);
    check("rst_underrun", pkt_underrun, 1'b0);
    rst = 1'b0;

    // Idle link: logical idle, then COM + 3 SKP every SKP_INTERVAL from the 16th edge.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      p       = (k >= 16) ? (k - 16) % 16 : -1;
      exp_sym = (p == 2) ? 9'h1BC : (p >= 3 && p <= 5) ? 9'h11C : 9'h000;
      exp_st  = (p == 1) ? 2'd2 : (p >= 2 && p <= 4) ? 2'd3 : 2'd0;
      check("idle_sym",   {23'd0, control_tx, datain_tx_unencoded}, {23'd0, exp_sym});
      check("idle_state", sched_state, exp_st);
      check("idle_ready", tl.tl_ready, !(p >= 0 && p <= 4));
      check("idle_sent",  skp_sent, (p == 5));
    end
    check("idle_overrun", skp_overrun, 1'b0);

    // Packet spanning a wrap: COM follows the last symbol directly.
    do_reset();
    repeat (8) @(negedge clk);
    send_pkt(12, 8'h40, -1, 0);
    @(negedge clk);
    check("span_com", {23'd0, control_tx, datain_tx_unencoded}, 32'h1BC);

    // Two-cycle starvation mid-packet.
    u0 = underruns;
    send_pkt(10, 8'h20, 4, 2);
    repeat (6) @(negedge clk);
    check("underrun_count", underruns - u0, 2);
    check("sb_drained_a", sb.size(), 0);

    // Packet longer than two intervals: sticky overrun, single SKP set afterwards.
    do_reset();
    s0 = sets;
    send_pkt(40, 8'h60, -1, 0);
    check("long_overrun", skp_overrun, 1'b1);
    @(negedge clk);
    check("long_com", {23'd0, control_tx, datain_tx_unencoded}, 32'h1BC);
    repeat (4) @(negedge clk);
    check("long_one_set", sets - s0, 1);
    repeat (20) @(negedge clk);
    check("long_overrun_sticky", skp_overrun, 1'b1);
    check("sb_drained_b", sb.size(), 0);

    // Reset in the middle of an ordered set.
    do_reset();
    repeat (19) @(negedge clk);
    check("mid_first_skp", {23'd0, control_tx, datain_tx_unencoded}, 32'h11C);
    rst = 1'b1;
    #1;
    check("mid_rst_data",  datain_tx_unencoded, 8'h00);
    check("mid_rst_ctl",   control_tx, 1'b0);
    check("mid_rst_state", sched_state, 2'd0);
    check("mid_rst_ready", tl.tl_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 15) begin
        check("post_rst_sym",   {23'd0, control_tx, datain_tx_unencoded}, 32'h000);
        check("post_rst_state", sched_state, 2'd0);
      end
    end
    check("post_rst_com_state", sched_state, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
